// File: rtl/freq_divider_pkg.sv
// freq_divider_pkg
//   Shared definitions for the integer clock divider.
//   - phase_e          : which half of the divided period the output is in.
//   - low_phase_len()  : number of clk_in cycles spent low per period.
//                        For odd divisors the spare cycle goes to the high phase.
package freq_divider_pkg;

    typedef enum logic {
        PHASE_LOW  = 1'b0,
        PHASE_HIGH = 1'b1
    } phase_e;

    function automatic int low_phase_len(input int divisor);
        return divisor / 2;
    endfunction

endpackage

// File: rtl/freq_divider.sv
// freq_divider
//   Parameterised integer clock divider. Produces a registered, glitch-free
//   square wave with a period of exactly DIVISOR clk_in cycles. The output is
//   low for floor(DIVISOR/2) cycles, then high for the rest of the period. A
//   one-cycle tick marks the last high cycle of each period. Fast-domain logic
//   can use tick as a clock enable instead of clocking from clk_out.
//
// Parameters
//   DIVISOR : clk_in cycles per clk_out period (2 <= DIVISOR < 2**WIDTH)
//   WIDTH   : counter width in bits
//
// Ports
//   clk_in  : input  system clock, all state changes on its rising edge
//   rst     : input  synchronous active-high reset
//   clk_out : output divided clock (registered)
//   tick    : output pulse on the final cycle of each clk_out period (registered)
module freq_divider
    import freq_divider_pkg::*;
#(
    parameter int DIVISOR = 12000,
    parameter int WIDTH   = 28
) (
    input  logic clk_in,
    input  logic rst,
    output logic clk_out,
    output logic tick
);

    // Out-of-range divisors have no defined behaviour; stop at elaboration.
    generate
        if (DIVISOR < 2 || longint'(DIVISOR) >= (64'sd1 <<< WIDTH)) begin : g_bad_divisor
            $error("freq_divider: DIVISOR must satisfy 2 <= DIVISOR < 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(DIVISOR - 1);
    localparam logic [WIDTH-1:0] LOW_LEN  = WIDTH'(low_phase_len(DIVISOR));

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    phase_e           phase_next;
    logic             tick_next;

    // Outputs are computed from the next count so that registering them
    // keeps them aligned with the count value they describe, with no
    // combinational path from any input to any output.
    always_comb begin
        cnt_next   = '0;
        phase_next = PHASE_LOW;
        tick_next  = 1'b0;
        if (cnt != TERMINAL) begin
            cnt_next = cnt + WIDTH'(1);
        end
        if (cnt_next >= LOW_LEN) begin
            phase_next = PHASE_HIGH;
        end
        tick_next = (cnt_next == TERMINAL);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            clk_out <= (phase_next == PHASE_HIGH);
            tick    <= tick_next;
        end
    end

endmodule

// File: tb/tb_freq_divider.sv
// tb_freq_divider
//   Directed bench for freq_divider. Several dividers with different DIVISOR
//   values share one clock and reset. After reset is released at a falling
//   edge, the sample taken k falling edges later reflects k rising edges of
//   counting, so the expected count is k mod D, clk_out = (k mod D) >= D/2
//   and tick = (k mod D) == D-1.
module tb_freq_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic co_12000, tk_12000;
    logic co_5, tk_5;
    logic co_2, tk_2;
    logic co_10, tk_10;
    logic co_4, tk_4;
    logic co_3, tk_3;
    logic co_7, tk_7;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    freq_divider #(.DIVISOR(12000), .WIDTH(28)) u_d12000 (.clk_in(clk), .rst(rst), .clk_out(co_12000), .tick(tk_12000));
    freq_divider #(.DIVISOR(5),     .WIDTH(28)) u_d5     (.clk_in(clk), .rst(rst), .clk_out(co_5),     .tick(tk_5));
    freq_divider #(.DIVISOR(2),     .WIDTH(28)) u_d2     (.clk_in(clk), .rst(rst), .clk_out(co_2),     .tick(tk_2));
    freq_divider #(.DIVISOR(10),    .WIDTH(28)) u_d10    (.clk_in(clk), .rst(rst), .clk_out(co_10),    .tick(tk_10));
    freq_divider #(.DIVISOR(4),     .WIDTH(28)) u_d4     (.clk_in(clk), .rst(rst), .clk_out(co_4),     .tick(tk_4));
    freq_divider #(.DIVISOR(3),     .WIDTH(8))  u_d3     (.clk_in(clk), .rst(rst), .clk_out(co_3),     .tick(tk_3));
    freq_divider #(.DIVISOR(7),     .WIDTH(8))  u_d7     (.clk_in(clk), .rst(rst), .clk_out(co_7),     .tick(tk_7));

    // Hold reset for n cycles, release at a falling edge (sample index 0).
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3);
        tests_run++;
        if ({co_12000, tk_12000, co_5, tk_5, co_2, tk_2, co_10, tk_10,
             co_4, tk_4, co_3, tk_3, co_7, tk_7} !== 14'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {co_12000, tk_12000, co_5, tk_5, co_2, tk_2, co_10, tk_10,
                      co_4, tk_4, co_3, tk_3, co_7, tk_7});
        end
    endtask

    // D=12000 over 5 periods, with D=3 and D=7 checked cycle by cycle alongside.
    task automatic test_long_run();
        int  first_rise = -1;
        int  first_fall = -1;
        int  ticks = 0;
        int  hi12 = 0, hi3 = 0, hi7 = 0;
        bit  prev = 1'b0;
        bit  bad12 = 1'b0, bad3 = 1'b0, bad7 = 1'b0;
        do_reset(3);
        for (int k = 0; k <= 60000; k++) begin
            if (k > 0) @(negedge clk);
            if (!bad12) begin
                tests_run++;
                if (co_12000 !== ((k % 12000) >= 6000) || tk_12000 !== ((k % 12000) == 11999)) begin
                    tests_failed++;
                    bad12 = 1'b1;
                    $display("FAIL d12000_cycle k=%0d: got clk_out=%b tick=%b expected clk_out=%b tick=%b",
                             k, co_12000, tk_12000, (k % 12000) >= 6000, (k % 12000) == 11999);
                end
            end
            if (!bad3) begin
                tests_run++;
                if (co_3 !== ((k % 3) >= 1) || tk_3 !== ((k % 3) == 2)) begin
                    tests_failed++;
                    bad3 = 1'b1;
                    $display("FAIL d3_cycle k=%0d: got clk_out=%b tick=%b expected clk_out=%b tick=%b",
                             k, co_3, tk_3, (k % 3) >= 1, (k % 3) == 2);
                end
            end
            if (!bad7) begin
                tests_run++;
                if (co_7 !== ((k % 7) >= 3) || tk_7 !== ((k % 7) == 6)) begin
                    tests_failed++;
                    bad7 = 1'b1;
                    $display("FAIL d7_cycle k=%0d: got clk_out=%b tick=%b expected clk_out=%b tick=%b",
                             k, co_7, tk_7, (k % 7) >= 3, (k % 7) == 6);
                end
            end
            if (co_12000 && !prev && first_rise < 0) first_rise = k;
            if (!co_12000 && prev && first_fall < 0) first_fall = k;
            prev = co_12000;
            if (tk_12000 === 1'b1) ticks++;
            if (k < 12000 && co_12000 === 1'b1) hi12++;
            if (k < 3 && co_3 === 1'b1) hi3++;
            if (k < 7 && co_7 === 1'b1) hi7++;
        end
        tests_run++;
        if (first_rise !== 6000) begin
            tests_failed++;
            $display("FAIL d12000_first_rise: got %0d expected 6000", first_rise);
        end
        tests_run++;
        if (first_fall !== 12000) begin
            tests_failed++;
            $display("FAIL d12000_first_fall: got %0d expected 12000", first_fall);
        end
        tests_run++;
        if (ticks !== 5) begin
            tests_failed++;
            $display("FAIL d12000_tick_count: got %0d expected 5", ticks);
        end
        tests_run++;
        if (hi12 !== 6000) begin
            tests_failed++;
            $display("FAIL d12000_duty: got %0d high cycles expected 6000", hi12);
        end
        tests_run++;
        if (hi3 !== 2) begin
            tests_failed++;
            $display("FAIL d3_duty: got %0d high cycles expected 2", hi3);
        end
        tests_run++;
        if (hi7 !== 4) begin
            tests_failed++;
            $display("FAIL d7_duty: got %0d high cycles expected 4", hi7);
        end
    endtask

    task automatic test_div5();
        logic [4:0] exp_co = 5'b11100; // bit i = expected clk_out at phase i
        logic [4:0] exp_tk = 5'b10000;
        do_reset(2);
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (co_5 !== exp_co[k % 5] || tk_5 !== exp_tk[k % 5]) begin
                tests_failed++;
                $display("FAIL d5_pattern k=%0d: got clk_out=%b tick=%b expected clk_out=%b tick=%b",
                         k, co_5, tk_5, exp_co[k % 5], exp_tk[k % 5]);
                break;
            end
        end
    endtask

    task automatic test_div2();
        do_reset(2);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (co_2 !== k[0] || tk_2 !== k[0]) begin
                tests_failed++;
                $display("FAIL d2_toggle k=%0d: got clk_out=%b tick=%b expected %b for both",
                         k, co_2, tk_2, k[0]);
                break;
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset(2);
        repeat (7) @(negedge clk);
        tests_run++;
        if (co_10 !== 1'b1) begin
            tests_failed++;
            $display("FAIL d10_high_before_reset: got clk_out=%b expected 1", co_10);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (co_10 !== (k % 10 >= 5) || tk_10 !== (k % 10 == 9)) begin
                tests_failed++;
                $display("FAIL d10_after_reset k=%0d: got clk_out=%b tick=%b expected clk_out=%b tick=%b",
                         k, co_10, tk_10, k % 10 >= 5, k % 10 == 9);
                break;
            end
        end
    endtask

    task automatic test_reset_held();
        int first_rise = -1;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            tests_run++;
            if (co_4 !== 1'b0 || tk_4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL d4_held_reset k=%0d: got clk_out=%b tick=%b expected 0 0", k, co_4, tk_4);
                break;
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (co_4 === 1'b1 && first_rise < 0) first_rise = k;
            tests_run++;
            if (co_4 !== (k % 4 >= 2) || tk_4 !== (k % 4 == 3)) begin
                tests_failed++;
                $display("FAIL d4_after_release k=%0d: got clk_out=%b tick=%b expected clk_out=%b tick=%b",
                         k, co_4, tk_4, k % 4 >= 2, k % 4 == 3);
                break;
            end
        end
        tests_run++;
        if (first_rise !== 2) begin
            tests_failed++;
            $display("FAIL d4_first_rise: got %0d expected 2", first_rise);
        end
    endtask

    initial begin
        test_reset();
        test_div5();
        test_div2();
        test_mid_reset();
        test_reset_held();
        test_long_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
